// File: rtl/demux1x4_tdm.sv
// -----------------------------------------------------------------------------
// demux1x4_tdm
//
// Receiving end of a TDM link. One data lane carries one sample per valid
// cycle, with slots rotating ch0 .. ch(N_CH-1). frame_sync marks the ch0
// sample. The block locks onto frame_sync and steers each sample into a
// shadow register for its slot. When the last slot arrives, it publishes the
// complete frame on ch_out in a single update.
//
// Optional feature, selected by the macro DEMUX_SYNC_CHECK_EN:
//   defined   : strict mode. A slot-0 sample that arrives without frame_sync
//               while locked counts as loss of alignment. The block raises
//               sync_err, drops the sample and goes back to hunting.
//   undefined : flywheel mode. Once locked, the block trusts its own slot
//               counter and accepts a slot-0 sample that has no frame_sync.
//
// Naming: every flop is <sig>_q and is loaded from <sig>_d, which is
// computed in an always_comb block.
// -----------------------------------------------------------------------------
module demux1x4_tdm #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int SW   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      d_in,
    input  logic              d_valid,
    input  logic              frame_sync,
    output logic [N_CH*W-1:0] ch_out,
    output logic [SW-1:0]     slot,
    output logic              locked,
    output logic              frame_done,
    output logic              sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

    // Single-lane decode events. In each cycle at most one of them is true.
    logic ev_start;    // sync sample seen while hunting
    logic ev_early;    // sync arrived before the frame was complete
    logic ev_unlock;   // strict mode only: slot 0 arrived without sync
    logic ev_capture;  // ordinary in-frame sample while locked

    state_e state_q, state_d;

    logic [SW-1:0]     slot_q, slot_d;
    logic [W-1:0]      shadow_q [N_CH];
    logic [W-1:0]      shadow_d [N_CH];
    logic [N_CH*W-1:0] ch_out_q, ch_out_d;
    logic              frame_done_q, frame_done_d;
    logic              sync_err_q, sync_err_d;
    logic              locked_q, locked_d;

    // Classify the current cycle. A cycle without d_valid produces no event,
    // so frame_sync has no effect in that cycle.
    always_comb begin
        ev_start   = 1'b0;
        ev_early   = 1'b0;
        ev_unlock  = 1'b0;
        ev_capture = 1'b0;
        if (d_valid) begin
            if (state_q == HUNT) begin
                ev_start = frame_sync;
            end else if (frame_sync && (slot_q != '0)) begin
                ev_early = 1'b1;
            end else if (!frame_sync && (slot_q == '0)) begin
`ifdef DEMUX_SYNC_CHECK_EN
                ev_unlock  = 1'b1;
`else
                ev_capture = 1'b1;
`endif
            end else begin
                ev_capture = 1'b1;
            end
        end
    end

    // State register.
    // NOTE: sequential blocks use non-blocking (<=) assignments only. Then
    // every flop samples the values from before the clock edge, and the
    // order of the statements does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A sync sample locks the block. In strict mode,
    // losing alignment unlocks it.
    always_comb begin
        // NOTE: each always_comb assigns a default first, so that no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            HUNT:    if (ev_start)  state_d = LOCKED;
            LOCKED:  if (ev_unlock) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Datapath and output logic: route the sample to its slot, advance the
    // slot counter, publish the frame after the last slot, and form the
    // one-cycle pulses.
    always_comb begin
        slot_d       = slot_q;
        shadow_d     = shadow_q;
        ch_out_d     = ch_out_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (ev_start) begin
            shadow_d[0] = d_in;
            slot_d      = SLOT_ONE;
        end else if (ev_early) begin
            // Drop the partial frame. The stale shadow entries are
            // overwritten before the realigned frame can complete.
            sync_err_d  = 1'b1;
            shadow_d[0] = d_in;
            slot_d      = SLOT_ONE;
        end else if (ev_unlock) begin
            // Discard the sample. ch_out keeps the last good frame.
            sync_err_d = 1'b1;
            slot_d     = '0;
        end else if (ev_capture) begin
            shadow_d[slot_q] = d_in;
            if (slot_q == LAST_SLOT) begin
                // The last sample goes straight into ch_out. All lanes then
                // change on the same edge and ch_out is never partly updated.
                for (int k = 0; k < N_CH - 1; k++) begin
                    ch_out_d[k*W +: W] = shadow_q[k];
                end
                ch_out_d[(N_CH-1)*W +: W] = d_in;
                frame_done_d = 1'b1;
                slot_d       = '0;
            end else begin
                slot_d = slot_q + SLOT_ONE;
            end
        end
    end

    // locked is registered from the next state. It therefore changes on the
    // same edge as the state register.
    always_comb begin
        locked_d = (state_d == LOCKED);
    end

    // Datapath and output registers.
    // NOTE: the shadow array is reset together with the other registers. It
    // is small, and a reset in the middle of a frame must leave no earlier
    // samples behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q       <= '0;
            ch_out_q     <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            locked_q     <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            slot_q       <= slot_d;
            ch_out_q     <= ch_out_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            locked_q     <= locked_d;
            for (int k = 0; k < N_CH; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    assign ch_out     = ch_out_q;
    assign slot       = slot_q;
    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_demux1x4_tdm.sv
// -----------------------------------------------------------------------------
// Testbench for demux1x4_tdm (N_CH=4, W=8).
// A table of per-cycle vectors gives the expected outputs after each edge.
// Frames that should be published are pushed to a scoreboard queue when their
// last sample is driven, and popped when the DUT pulses frame_done.
// -----------------------------------------------------------------------------
module tb_demux1x4_tdm;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int SW   = $clog2(N_CH);

    logic              clk;
    logic              rst_n;
    logic [W-1:0]      d_in;
    logic              d_valid;
    logic              frame_sync;
    logic [N_CH*W-1:0] ch_out;
    logic [SW-1:0]     slot;
    logic              locked;
    logic              frame_done;
    logic              sync_err;

    demux1x4_tdm #(.N_CH(N_CH), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_in       (d_in),
        .d_valid    (d_valid),
        .frame_sync (frame_sync),
        .ch_out     (ch_out),
        .slot       (slot),
        .locked     (locked),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              valid;
        logic              sync;
        logic [W-1:0]      data;
        logic              push;      // last sample of a frame that should publish
        logic              e_locked;
        logic [SW-1:0]     e_slot;
        logic              e_done;
        logic              e_err;
        logic [N_CH*W-1:0] e_ch;
    } vec_t;

    vec_t              vecs[$];
    logic [N_CH*W-1:0] sb[$];
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N_CH*W-1:0] frame(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                                input logic [W-1:0] c2, input logic [W-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic add(input logic v, input logic s, input logic [W-1:0] d, input logic p,
                       input logic el, input int es, input logic ed, input logic ee,
                       input logic [N_CH*W-1:0] ec);
        vec_t t;
        t.valid = v; t.sync = s; t.data = d; t.push = p;
        t.e_locked = el; t.e_slot = SW'(es); t.e_done = ed; t.e_err = ee; t.e_ch = ec;
        vecs.push_back(t);
    endtask

    // Drive one cycle. Before the edge, push the expected frame if this is the
    // last sample. After the edge, service the frame scoreboard.
    task automatic step(input logic v, input logic s, input logic [W-1:0] d, input logic p,
                        input logic [N_CH*W-1:0] pf);
        d_valid = v; frame_sync = s; d_in = d;
        if (p) sb.push_back(pf);
        @(posedge clk);
        #1;
        if (frame_done) begin
            if (sb.size() == 0) begin
                check("unexpected_frame_done", 64'(frame_done), 64'(0));
            end else begin
                check("scoreboard_frame", 64'(ch_out), 64'(sb.pop_front()));
            end
        end
    endtask

    task automatic check_outputs(input string tag, input logic el, input logic [SW-1:0] es,
                                 input logic ed, input logic ee, input logic [N_CH*W-1:0] ec);
        check({tag, ".locked"},     64'(locked),     64'(el));
        check({tag, ".slot"},       64'(slot),       64'(es));
        check({tag, ".frame_done"}, 64'(frame_done), 64'(ed));
        check({tag, ".sync_err"},   64'(sync_err),   64'(ee));
        check({tag, ".ch_out"},     64'(ch_out),     64'(ec));
    endtask

    initial begin
        logic [N_CH*W-1:0] fa, fb, fd, fe, f1;
        fa = frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        fb = frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        fd = frame(8'hD0, 8'hD1, 8'hD2, 8'hD3);
        fe = frame(8'hE0, 8'hE1, 8'hE2, 8'hE3);
        f1 = frame(8'h01, 8'h02, 8'h03, 8'h04);

        // Scenario 1: unsynced samples are ignored while hunting. A sync
        // without d_valid is ignored as well.
        add(1, 0, 8'h11, 0, 0, 0, 0, 0, '0);
        add(1, 0, 8'h22, 0, 0, 0, 0, 0, '0);
        add(0, 1, 8'h99, 0, 0, 0, 0, 0, '0);
        add(1, 0, 8'h33, 0, 0, 0, 0, 0, '0);
        // Scenario 2: lock, and receive one back-to-back frame.
        add(1, 1, 8'hA0, 0, 1, 1, 0, 0, '0);
        add(1, 0, 8'hA1, 0, 1, 2, 0, 0, '0);
        add(1, 0, 8'hA2, 0, 1, 3, 0, 0, '0);
        add(1, 0, 8'hA3, 1, 1, 0, 1, 0, fa);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, fa);
        // Scenario 3: frame with two-cycle gaps. A sync during a gap is ignored.
        add(1, 1, 8'hB0, 0, 1, 1, 0, 0, fa);
        add(0, 0, 8'h00, 0, 1, 1, 0, 0, fa);
        add(0, 1, 8'h55, 0, 1, 1, 0, 0, fa);
        add(1, 0, 8'hB1, 0, 1, 2, 0, 0, fa);
        add(0, 0, 8'h00, 0, 1, 2, 0, 0, fa);
        add(0, 0, 8'h00, 0, 1, 2, 0, 0, fa);
        add(1, 0, 8'hB2, 0, 1, 3, 0, 0, fa);
        add(0, 0, 8'h00, 0, 1, 3, 0, 0, fa);
        add(0, 0, 8'h00, 0, 1, 3, 0, 0, fa);
        add(1, 0, 8'hB3, 1, 1, 0, 1, 0, fb);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, fb);
        // Scenario 4: early sync drops the partial frame.
        add(1, 1, 8'hC0, 0, 1, 1, 0, 0, fb);
        add(1, 0, 8'hC1, 0, 1, 2, 0, 0, fb);
        add(1, 1, 8'hD0, 0, 1, 1, 0, 1, fb);
        add(1, 0, 8'hD1, 0, 1, 2, 0, 0, fb);
        add(1, 0, 8'hD2, 0, 1, 3, 0, 0, fb);
        add(1, 0, 8'hD3, 1, 1, 0, 1, 0, fd);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, fd);
        // Scenario 5: slot-0 sample without sync.
`ifdef DEMUX_SYNC_CHECK_EN
        add(1, 0, 8'hE0, 0, 0, 0, 0, 1, fd);
        add(1, 0, 8'hE1, 0, 0, 0, 0, 0, fd);
        add(1, 0, 8'hE2, 0, 0, 0, 0, 0, fd);
        add(1, 0, 8'hE3, 0, 0, 0, 0, 0, fd);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, fd);
`else
        add(1, 0, 8'hE0, 0, 1, 1, 0, 0, fd);
        add(1, 0, 8'hE1, 0, 1, 2, 0, 0, fd);
        add(1, 0, 8'hE2, 0, 1, 3, 0, 0, fd);
        add(1, 0, 8'hE3, 1, 1, 0, 1, 0, fe);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, fe);
`endif

        // Reset and check the reset state.
        rst_n = 1'b0; d_valid = 1'b0; frame_sync = 1'b0; d_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, '0, 0, 0, '0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].valid, vecs[i].sync, vecs[i].data, vecs[i].push, vecs[i].e_ch);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_locked, vecs[i].e_slot,
                          vecs[i].e_done, vecs[i].e_err, vecs[i].e_ch);
        end

        // Scenario 6: asynchronous reset in the middle of a frame.
        step(1, 1, 8'hF0, 0, '0);
        step(1, 0, 8'hF1, 0, '0);
        check("pre_reset.locked", 64'(locked), 64'(1));
        check("pre_reset.slot",   64'(slot),   64'(2));
        d_valid = 1'b0; frame_sync = 1'b0;
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", 0, '0, 0, 0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 1, 8'h01, 0, '0);
        check_outputs("post_reset_s0", 1, SW'(1), 0, 0, '0);
        step(1, 0, 8'h02, 0, '0);
        step(1, 0, 8'h03, 0, '0);
        step(1, 0, 8'h04, 1, f1);
        check_outputs("post_reset_frame", 1, '0, 1, 0, f1);
        step(0, 0, 8'h00, 0, '0);
        check("post_reset_pulse_end", 64'(frame_done), 64'(0));
        check("post_reset_hold",      64'(ch_out),     64'(f1));

        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

endmodule
